// File: rtl/mcu_tx_uart_serializer.sv
// rtl/mcu_tx_uart_serializer.sv - 32-bit word to four LSB-first UART frames
// Captures one word per handshake and serialises its bytes back to back.
module mcu_tx_uart_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        tx_data_valid,
   input  logic [31:0] tx_data,
   output logic        tx_ack,
   output logic        uart_txd,
   output logic        busy,
   output logic        byte_done,
   output logic        word_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     word_q, word_d;
   logic [7:0]      shift_q, shift_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            stop_idx_q, stop_idx_d;
   logic            tx_ack_q, tx_ack_d;
   logic            txd_q, txd_d;
   logic            busy_q, busy_d;
   logic            byte_done_q, byte_done_d;
   logic            word_done_q, word_done_d;

   logic            bit_end;
   logic            stop_last;
   logic [1:0]      byte_nxt;

   assign bit_end   = (bit_cnt_q == BIT_LAST);
   assign stop_last = (STOP_BITS == 2) ? stop_idx_q : 1'b1;
   assign byte_nxt  = byte_idx_q + 2'd1;

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      shift_d     = shift_q;
      byte_idx_d  = byte_idx_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      txd_d       = txd_q;
      tx_ack_d    = 1'b0;
      byte_done_d = 1'b0;
      word_done_d = 1'b0;
      bit_cnt_d   = bit_end ? '0 : bit_cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            bit_cnt_d = '0;
            txd_d     = 1'b1;
            // The !tx_ack_q term blocks a second capture while upstream drops valid.
            if (enable && tx_data_valid && !tx_ack_q) begin
               word_d     = tx_data;
               shift_d    = tx_data[7:0];
               byte_idx_d = 2'd0;
               tx_ack_d   = 1'b1;
               txd_d      = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               txd_d     = shift_q[0];
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  txd_d      = 1'b1;
                  stop_idx_d = 1'b0;
                  state_d    = S_STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  txd_d     = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (stop_last) begin
                  byte_done_d = 1'b1;
                  // Next frame's start bit follows the stop bit with no idle gap.
                  if (byte_idx_q != 2'd3) begin
                     byte_idx_d = byte_nxt;
                     shift_d    = word_q[{byte_nxt, 3'b000} +: 8];
                     txd_d      = 1'b0;
                     state_d    = S_START;
                  end else begin
                     word_done_d = 1'b1;
                     state_d     = S_IDLE;
                  end
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         word_q      <= '0;
         shift_q     <= '0;
         byte_idx_q  <= '0;
         bit_idx_q   <= '0;
         bit_cnt_q   <= '0;
         stop_idx_q  <= 1'b0;
         tx_ack_q    <= 1'b0;
         txd_q       <= 1'b1;
         busy_q      <= 1'b0;
         byte_done_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         shift_q     <= shift_d;
         byte_idx_q  <= byte_idx_d;
         bit_idx_q   <= bit_idx_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_idx_q  <= stop_idx_d;
         tx_ack_q    <= tx_ack_d;
         txd_q       <= txd_d;
         busy_q      <= busy_d;
         byte_done_q <= byte_done_d;
         word_done_q <= word_done_d;
      end
   end

   assign tx_ack    = tx_ack_q;
   assign uart_txd  = txd_q;
   assign busy      = busy_q;
   assign byte_done = byte_done_q;
   assign word_done = word_done_q;

endmodule

// File: tb/tb_mcu_tx_uart_serializer.sv
// tb/tb_mcu_tx_uart_serializer.sv - directed bench for mcu_tx_uart_serializer
// Two instances: 4 clk/bit with 1 stop bit, and 3 clk/bit with 2 stop bits.
module tb_mcu_tx_uart_serializer;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        v_drv;
   logic [31:0] d_drv;
   logic        sel;

   logic valid1, ack1, txd1, busy1, bd1, wd1;
   logic valid2, ack2, txd2, busy2, bd2, wd2;
   logic ack_m, txd_m, busy_m, bd_m, wd_m;

   int total = 0;
   int bad   = 0;
   int n;

   assign valid1 = v_drv & ~sel;
   assign valid2 = v_drv & sel;
   assign ack_m  = sel ? ack2  : ack1;
   assign txd_m  = sel ? txd2  : txd1;
   assign busy_m = sel ? busy2 : busy1;
   assign bd_m   = sel ? bd2   : bd1;
   assign wd_m   = sel ? wd2   : wd1;

   mcu_tx_uart_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .tx_data_valid(valid1),
      .tx_data(d_drv), .tx_ack(ack1), .uart_txd(txd1), .busy(busy1),
      .byte_done(bd1), .word_done(wd1));

   mcu_tx_uart_serializer #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .tx_data_valid(valid2),
      .tx_data(d_drv), .tx_ack(ack2), .uart_txd(txd2), .busy(busy2),
      .byte_done(bd2), .word_done(wd2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Returns number of negedges until tx_ack is seen (limit+1 on timeout).
   task automatic wait_ack(input int limit, output int cnt);
      cnt = limit + 1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (ack_m === 1'b1) begin
            cnt = i;
            break;
         end
      end
   endtask

   // Called at the negedge where tx_ack is seen; checks every cycle of the word.
   task automatic check_word(input logic [31:0] w, input int cpb, input int nstop,
                             input int hold, input logic nv, input logic [31:0] nd,
                             input bit drop_en);
      int k;
      logic expb;
      logic [4:0] exp_v;
      k = 0;
      for (int f = 0; f < 4; f++) begin
         for (int b = 0; b < 9 + nstop; b++) begin
            for (int c = 0; c < cpb; c++) begin
               if (k > 0) @(negedge clk);
               if (k == hold) begin
                  v_drv = nv;
                  d_drv = nd;
               end
               if (drop_en && k == 10 * cpb + 2) enable = 1'b0;
               if (b == 0)      expb = 1'b0;
               else if (b <= 8) expb = w[8*f + b - 1];
               else             expb = 1'b1;
               exp_v = {expb, 1'b1, (f == 0 && b == 0 && c == 0),
                        (f > 0 && b == 0 && c == 0), 1'b0};
               chk($sformatf("w%08h f%0d b%0d c%0d", w, f, b, c),
                   {27'd0, txd_m, busy_m, ack_m, bd_m, wd_m}, {27'd0, exp_v});
               k++;
            end
         end
      end
      @(negedge clk);
      chk($sformatf("w%08h idle", w), {27'd0, txd_m, busy_m, ack_m, bd_m, wd_m},
          {27'd0, 5'b10011});
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      v_drv   = 1'b0;
      d_drv   = '0;
      sel     = 1'b0;

      @(negedge clk);
      chk("reset dut1", {27'd0, txd1, busy1, ack1, bd1, wd1}, {27'd0, 5'b10000});
      chk("reset dut2", {27'd0, txd2, busy2, ack2, bd2, wd2}, {27'd0, 5'b10000});
      @(negedge clk);
      reset_n = 1'b1;
      enable  = 1'b1;
      @(negedge clk);
      chk("idle no valid", {27'd0, txd1, busy1, ack1}, {27'd0, 3'b100});

      // Single word, 4 clk/bit
      v_drv = 1'b1;
      d_drv = 32'hA53C0F81;
      wait_ack(20, n);
      chk("ack latency A53C0F81", n, 1);
      check_word(32'hA53C0F81, 4, 1, 0, 1'b0, 32'h0, 1'b0);

      // Back-to-back words
      v_drv = 1'b1;
      d_drv = 32'h00000000;
      wait_ack(20, n);
      chk("ack latency 00000000", n, 1);
      check_word(32'h00000000, 4, 1, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
      wait_ack(20, n);
      chk("b2b gap FFFFFFFF", n, 1);
      check_word(32'hFFFFFFFF, 4, 1, 0, 1'b0, 32'h0, 1'b0);

      // Slow upstream keeps valid 2 cycles past ack
      v_drv = 1'b1;
      d_drv = 32'h5A5AC3C3;
      wait_ack(20, n);
      chk("ack latency 5A5AC3C3", n, 1);
      check_word(32'h5A5AC3C3, 4, 1, 2, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("no recapture %0d", i), {29'd0, txd1, busy1, ack1}, {29'd0, 3'b100});
      end

      // enable dropped during byte 1
      v_drv = 1'b1;
      d_drv = 32'h13579BDF;
      wait_ack(20, n);
      chk("ack latency 13579BDF", n, 1);
      check_word(32'h13579BDF, 4, 1, 0, 1'b1, 32'h2468ACE0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("enable hold %0d", i), {29'd0, txd1, busy1, ack1}, {29'd0, 3'b100});
      end
      enable = 1'b1;
      wait_ack(20, n);
      chk("ack after enable", n, 1);
      check_word(32'h2468ACE0, 4, 1, 0, 1'b0, 32'h0, 1'b0);

      // Async reset mid-DATA
      v_drv = 1'b1;
      d_drv = 32'h00000000;
      wait_ack(20, n);
      chk("ack latency reset word", n, 1);
      v_drv = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid data", {30'd0, txd1, busy1}, {30'd0, 2'b01});
      #2;
      reset_n = 1'b0;
      #1;
      chk("async reset", {27'd0, txd1, busy1, ack1, bd1, wd1}, {27'd0, 5'b10000});
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("post reset %0d", i), {27'd0, txd1, busy1, ack1, bd1, wd1},
             {27'd0, 5'b10000});
      end

      // 2 stop bits, 3 clk/bit
      sel   = 1'b1;
      v_drv = 1'b1;
      d_drv = 32'h12345678;
      wait_ack(20, n);
      chk("ack latency 12345678", n, 1);
      check_word(32'h12345678, 3, 2, 0, 1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
